// File: rtl/layer_tile_sched.sv
// -----------------------------------------------------------------------------
// layer_tile_sched
//
// Purpose:
//   Sequences one layer of weight-stationary work for the systolic-array compute
//   controller. It accepts a layer descriptor and splits it into weight tiles.
//   For each tile it issues one compute job and waits for that job's completion
//   pulse. Each layer ends with a one-cycle layer_done pulse, or with a sticky
//   timeout_err if a job never completes.
//
// Ports:
//   clk, rstn           clock and asynchronous active-low reset
//   cfg_valid/ready     descriptor handshake; cfg_ready is high only while idle
//   cfg_num_row         input rows per job
//   cfg_num_tile        number of weight tiles (0 finishes the layer at once)
//   cfg_*_base          layer base addresses (weights, inputs, accumulators)
//   abort               finish the layer after the job in flight completes
//   job_en              one-cycle job start strobe to the compute controller
//   job_weight_fill     this job loads its weights (first tile only)
//   job_weight_change   prefetch the next tile's weights during this job
//   job_num_row, job_*_addr  job fields; they hold until the next job_en
//   job_done            completion pulse from the compute controller
//   busy, tile_idx      status: not idle, index of the current tile
//   layer_done/aborted  one-cycle end-of-layer pulse, plus its abort flag
//   timeout_err         sticky; cleared when the next descriptor is accepted
// -----------------------------------------------------------------------------
module layer_tile_sched #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int SYS_ROW    = 16,
    parameter int TILE_W     = 8,
    parameter int TIMEOUT    = 4096
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [DATA_WIDTH-1:0] cfg_num_row,
    input  logic [TILE_W-1:0]     cfg_num_tile,
    input  logic [ADDR_WIDTH-1:0] cfg_w_base,
    input  logic [ADDR_WIDTH-1:0] cfg_in_base,
    input  logic [ADDR_WIDTH-1:0] cfg_acc_base,
    input  logic                  abort,
    output logic                  job_en,
    output logic                  job_weight_fill,
    output logic                  job_weight_change,
    output logic [DATA_WIDTH-1:0] job_num_row,
    output logic [ADDR_WIDTH-1:0] job_w_addr,
    output logic [ADDR_WIDTH-1:0] job_in_addr,
    output logic [ADDR_WIDTH-1:0] job_acc_addr,
    input  logic                  job_done,
    output logic                  busy,
    output logic [TILE_W-1:0]     tile_idx,
    output logic                  layer_done,
    output logic                  aborted,
    output logic                  timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [TILE_W-1:0]     TILE_ONE   = {{(TILE_W-1){1'b0}}, 1'b1};
    localparam logic [TILE_W:0]       TILE_ONE_X = {{TILE_W{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] W_STRIDE   = ADDR_WIDTH'(SYS_ROW);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                  state_q;
    logic [DATA_WIDTH-1:0]   num_row_q;
    logic [TILE_W-1:0]       num_tile_q;
    logic [ADDR_WIDTH-1:0]   w_base_q;
    logic [ADDR_WIDTH-1:0]   in_base_q;
    logic [ADDR_WIDTH-1:0]   acc_base_q;
    logic [ADDR_WIDTH-1:0]   w_off_q;
    logic [ADDR_WIDTH-1:0]   acc_off_q;
    logic [CNT_W-1:0]        wait_cnt_q;
    logic                    abort_pend_q;

    logic                    cfg_ready_q;
    logic                    job_en_q;
    logic                    job_weight_fill_q;
    logic                    job_weight_change_q;
    logic [DATA_WIDTH-1:0]   job_num_row_q;
    logic [ADDR_WIDTH-1:0]   job_w_addr_q;
    logic [ADDR_WIDTH-1:0]   job_in_addr_q;
    logic [ADDR_WIDTH-1:0]   job_acc_addr_q;
    logic                    busy_q;
    logic [TILE_W-1:0]       tile_idx_q;
    logic                    layer_done_q;
    logic                    aborted_q;
    logic                    timeout_err_q;

    // Tile sequencer: state, descriptor, offsets and all registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q             <= S_IDLE;
            num_row_q           <= {DATA_WIDTH{1'b0}};
            num_tile_q          <= {TILE_W{1'b0}};
            w_base_q            <= {ADDR_WIDTH{1'b0}};
            in_base_q           <= {ADDR_WIDTH{1'b0}};
            acc_base_q          <= {ADDR_WIDTH{1'b0}};
            w_off_q             <= {ADDR_WIDTH{1'b0}};
            acc_off_q           <= {ADDR_WIDTH{1'b0}};
            wait_cnt_q          <= {CNT_W{1'b0}};
            abort_pend_q        <= 1'b0;
            cfg_ready_q         <= 1'b1;
            job_en_q            <= 1'b0;
            job_weight_fill_q   <= 1'b0;
            job_weight_change_q <= 1'b0;
            job_num_row_q       <= {DATA_WIDTH{1'b0}};
            job_w_addr_q        <= {ADDR_WIDTH{1'b0}};
            job_in_addr_q       <= {ADDR_WIDTH{1'b0}};
            job_acc_addr_q      <= {ADDR_WIDTH{1'b0}};
            busy_q              <= 1'b0;
            tile_idx_q          <= {TILE_W{1'b0}};
            layer_done_q        <= 1'b0;
            aborted_q           <= 1'b0;
            timeout_err_q       <= 1'b0;
        end else begin
            // Strobes default low; only ISSUE and DONE raise them.
            job_en_q     <= 1'b0;
            layer_done_q <= 1'b0;
            aborted_q    <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    // cfg_ready lags entry to IDLE by one cycle, so accepting
                    // on the registered ready keeps the handshake consistent.
                    if (cfg_ready_q && cfg_valid) begin
                        num_row_q     <= cfg_num_row;
                        num_tile_q    <= cfg_num_tile;
                        w_base_q      <= cfg_w_base;
                        in_base_q     <= cfg_in_base;
                        acc_base_q    <= cfg_acc_base;
                        w_off_q       <= {ADDR_WIDTH{1'b0}};
                        acc_off_q     <= {ADDR_WIDTH{1'b0}};
                        tile_idx_q    <= {TILE_W{1'b0}};
                        timeout_err_q <= 1'b0;
                        abort_pend_q  <= 1'b0;
                        cfg_ready_q   <= 1'b0;
                        busy_q        <= 1'b1;
                        if (cfg_num_tile == {TILE_W{1'b0}}) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_ISSUE;
                        end
                    end else begin
                        cfg_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end

                S_ISSUE: begin
                    job_en_q            <= 1'b1;
                    job_weight_fill_q   <= (tile_idx_q == {TILE_W{1'b0}});
                    // One extra bit so tile_idx+1 cannot wrap at the top tile.
                    job_weight_change_q <= (({1'b0, tile_idx_q} + TILE_ONE_X) < {1'b0, num_tile_q});
                    job_num_row_q       <= num_row_q;
                    job_w_addr_q        <= w_base_q + w_off_q;
                    job_in_addr_q       <= in_base_q;
                    job_acc_addr_q      <= acc_base_q + acc_off_q;
                    wait_cnt_q          <= {CNT_W{1'b0}};
                    abort_pend_q        <= abort_pend_q | abort;
                    state_q             <= S_WAIT;
                end

                S_WAIT: begin
                    if (job_done) begin
                        // An abort arriving with job_done still stops here.
                        abort_pend_q <= abort_pend_q | abort;
                        if (abort_pend_q || abort || (tile_idx_q == (num_tile_q - TILE_ONE))) begin
                            state_q <= S_DONE;
                        end else begin
                            tile_idx_q <= tile_idx_q + TILE_ONE;
                            w_off_q    <= w_off_q + W_STRIDE;
                            acc_off_q  <= acc_off_q + ADDR_WIDTH'(num_row_q);
                            state_q    <= S_ISSUE;
                        end
                    end else if (wait_cnt_q == CNT_LAST) begin
                        // Give up on the job: flag it and return idle silently.
                        timeout_err_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= S_IDLE;
                    end else begin
                        wait_cnt_q   <= wait_cnt_q + CNT_ONE;
                        abort_pend_q <= abort_pend_q | abort;
                    end
                end

                S_DONE: begin
                    layer_done_q <= 1'b1;
                    aborted_q    <= abort_pend_q;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready         = cfg_ready_q;
    assign job_en            = job_en_q;
    assign job_weight_fill   = job_weight_fill_q;
    assign job_weight_change = job_weight_change_q;
    assign job_num_row       = job_num_row_q;
    assign job_w_addr        = job_w_addr_q;
    assign job_in_addr       = job_in_addr_q;
    assign job_acc_addr      = job_acc_addr_q;
    assign busy              = busy_q;
    assign tile_idx          = tile_idx_q;
    assign layer_done        = layer_done_q;
    assign aborted           = aborted_q;
    assign timeout_err       = timeout_err_q;

endmodule
